io_ccff_loader: RTL

Configuration-chain loader for the SOFA-Plus I/O tiles. It accepts a bitstream as WORD_W-bit words over a valid/ready handshake and shifts it serially, LSB first, into the `ccff_head` of an I/O-tile configuration chain of CHAIN_LEN flops. It gates `config_enable` for exactly CHAIN_LEN programming clocks and holds `IO_ISOL_N` low (pads isolated) until the chain is fully loaded and has settled. It sits between the SoC configuration port and the `ccff_head`/`ccff_tail`/`config_enable`/`IO_ISOL_N` inputs of the I/O grid.

---
 rtl/io_ccff_loader_if.sv | 17 +
 rtl/io_ccff_loader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/io_ccff_loader_if.sv
// Bitstream word channel between the SoC configuration port and the CCFF loader.
// Latency: none, wires only.
// Backpressure: a word moves on a clock edge where cfg_valid and cfg_ready are both high.
//
// Ports (modports):
//   master : drives cfg_data/cfg_valid, observes cfg_ready (SoC side)
//   slave  : observes cfg_data/cfg_valid, drives cfg_ready (loader side)
interface io_ccff_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (output cfg_data, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/io_ccff_loader.sv
// Serialises a word-wide bitstream LSB-first into an I/O-tile CCFF chain, gating
// config_enable for exactly CHAIN_LEN clocks and keeping the pads isolated until settled.
// Latency: first bit on ccff_head one cycle after a word is accepted; done SETTLE+1 cycles
// after the last shift. Backpressure: cfg_ready is high only in LOAD, so the source is
// stalled while a word is shifting and while the loader is idle, isolating or settling.
//
// Ports:
//   prog_clk, pReset_n : programming clock, async active-low reset
//   start, abort       : begin a load (IDLE only) / cancel a busy load (not in DONE)
//   cfg                : word channel (cfg_data, cfg_valid, cfg_ready)
//   ccff_head, config_enable, IO_ISOL_N : registered chain/pad controls
//   ccff_tail, tail_bit: chain tail and its one-cycle-delayed readback
//   busy, done, error  : status (done is a pulse, error is sticky until next start)
module io_ccff_loader #(
    parameter int CHAIN_LEN = 16,
    parameter int WORD_W    = 8,
    parameter int SETTLE    = 4
) (
    input  logic            prog_clk,
    input  logic            pReset_n,
    input  logic            start,
    input  logic            abort,
    io_ccff_loader_if.slave cfg,
    output logic            ccff_head,
    input  logic            ccff_tail,
    output logic            tail_bit,
    output logic            config_enable,
    output logic            IO_ISOL_N,
    output logic            busy,
    output logic            done,
    output logic            error
);
    localparam int BIT_W = $clog2(CHAIN_LEN + 1);
    localparam int WB_W  = $clog2(WORD_W + 1);
    localparam int ST_W  = $clog2(SETTLE + 1);

    localparam logic [BIT_W-1:0] C_CHAIN = BIT_W'(CHAIN_LEN);
    localparam logic [WB_W-1:0]  C_WORD  = WB_W'(WORD_W);
    localparam logic [ST_W-1:0]  C_STL   = ST_W'(SETTLE - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISOLATE = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_SHIFT   = 3'd3;
    localparam logic [2:0] S_SETTLE  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]        r_state;
    logic [WORD_W-1:0] r_sh;        // bits of the current word not yet presented
    logic [BIT_W-1:0]  r_bit_cnt;   // chain bits presented so far in this load
    logic [WB_W-1:0]   r_wbit;      // bits of the current word presented so far
    logic [ST_W-1:0]   r_settle;
    logic              r_head;
    logic              r_en;
    logic              r_isol_n;
    logic              r_done;
    logic              r_err;
    logic              r_tail;

    logic w_abort;

    // DONE is deliberately excluded: once settling has finished, completion wins.
    assign w_abort = abort && (r_state == S_ISOLATE || r_state == S_LOAD ||
                               r_state == S_SHIFT   || r_state == S_SETTLE);

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_state   <= S_IDLE;
            r_sh      <= '0;
            r_bit_cnt <= '0;
            r_wbit    <= '0;
            r_settle  <= '0;
            r_head    <= 1'b0;
            r_en      <= 1'b0;
            r_isol_n  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_tail    <= 1'b0;
        end else begin
            r_tail <= ccff_tail;
            r_done <= 1'b0;
            if (w_abort) begin
                // The chain itself keeps whatever was shifted so far; only the
                // loader state is cleared and the pads are re-isolated.
                r_state   <= S_IDLE;
                r_sh      <= '0;
                r_bit_cnt <= '0;
                r_wbit    <= '0;
                r_settle  <= '0;
                r_head    <= 1'b0;
                r_en      <= 1'b0;
                r_isol_n  <= 1'b0;
                r_err     <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            r_state   <= S_ISOLATE;
                            r_err     <= 1'b0;
                            r_isol_n  <= 1'b0;
                            r_bit_cnt <= '0;
                            r_wbit    <= '0;
                            r_settle  <= '0;
                        end
                    end
                    S_ISOLATE: r_state <= S_LOAD;
                    S_LOAD: begin
                        if (cfg.cfg_valid) begin
                            r_sh      <= cfg.cfg_data >> 1;
                            r_head    <= cfg.cfg_data[0];
                            r_en      <= 1'b1;
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            r_wbit    <= WB_W'(1);
                            r_state   <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        // Chain-full check comes first so a partial last word
                        // drops its unused upper bits.
                        if (r_bit_cnt == C_CHAIN) begin
                            r_state  <= S_SETTLE;
                            r_en     <= 1'b0;
                            r_head   <= 1'b0;
                            r_settle <= '0;
                        end else if (r_wbit == C_WORD) begin
                            r_state <= S_LOAD;
                            r_en    <= 1'b0;
                            r_head  <= 1'b0;
                        end else begin
                            r_head    <= r_sh[0];
                            r_sh      <= r_sh >> 1;
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            r_wbit    <= r_wbit + WB_W'(1);
                        end
                    end
                    S_SETTLE: begin
                        if (r_settle == C_STL) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_isol_n <= 1'b1;
                        end else begin
                            r_settle <= r_settle + ST_W'(1);
                        end
                    end
                    S_DONE: begin
                        r_state   <= S_IDLE;
                        r_bit_cnt <= '0;
                        r_wbit    <= '0;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign cfg.cfg_ready  = (r_state == S_LOAD);
    assign busy           = (r_state != S_IDLE);
    assign ccff_head      = r_head;
    assign config_enable  = r_en;
    assign IO_ISOL_N      = r_isol_n;
    assign done           = r_done;
    assign error          = r_err;
    assign tail_bit       = r_tail;
endmodule
